// File: rtl/a2d_seq.sv
// a2d_seq -- round-robin sequencer for the external 8-channel SPI A2D.
//
// Each conversion takes two SPI transactions with the same command word.
// The first transaction only loads the channel address into the A2D. The
// second returns that channel's 12-bit result, which is stored in the
// holding register the round-robin pointer selects. Four signals are
// sampled in turn: left load cell (ch0), right load cell (ch4), steering
// pot (ch5) and battery (ch6).
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   nxt        in   single-cycle request to start the next conversion
//   done       in   SPI master transaction complete (1-cycle pulse)
//   rd_data    in   [15:0] word received by the SPI master
//   wrt        out  SPI master start-transaction pulse (registered)
//   cmd        out  [15:0] SPI command word, held from one wrt to the next
//   lft_ld     out  [11:0] left load cell result   (ch0)
//   rght_ld    out  [11:0] right load cell result  (ch4)
//   steer_pot  out  [11:0] steering pot result     (ch5)
//   batt       out  [11:0] battery result          (ch6)
//   cnv_cmplt  out  1-cycle pulse after a result register updates
//   a2d_err    out  sticky SPI timeout flag, cleared only by reset
module a2d_seq #(
  parameter int TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        a2d_err
);

  // The counter is at least 12 bits wide and grows if TMO_CYCLES needs it.
  localparam int CW = ($clog2(TMO_CYCLES + 1) > 12) ? $clog2(TMO_CYCLES + 1) : 12;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    GAP,
    READ
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    rr_ptr;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]    chan;
  logic [15:0]   chan_cmd;
  logic          start_wrt;
  logic          capture;
  logic          tmo_hit;
  logic          timeout;
  logic          unused_hi;

  // The A2D returns only 12 significant bits. The top nibble is dropped.
  assign unused_hi = ^rd_data[15:12];

  // Map the round-robin slot to the physical A2D channel. The channel
  // number sits in bits [13:11] of the command word.
  always_comb begin
    chan = 3'd0;
    case (rr_ptr)
      2'd0:    chan = 3'd0;
      2'd1:    chan = 3'd4;
      2'd2:    chan = 3'd5;
      default: chan = 3'd6;
    endcase
    chan_cmd = {2'b00, chan, 11'h000};
  end

  // The counter was cleared on the wrt edge. When it reaches TMO_LAST, the
  // transaction has waited TMO_CYCLES clocks without a done.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the per-cycle decisions the datapath registers act
  // on. A done that arrives on the timeout clock wins over the timeout.
  always_comb begin
    state_nxt = state;
    start_wrt = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (nxt) begin
          start_wrt = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        if (done) begin
          state_nxt = GAP;
        end else if (tmo_hit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP: begin
        start_wrt = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        if (done) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers. A timeout leaves rr_ptr alone, so the next nxt
  // retries the same channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 2'd0;
      tmo_cnt   <= '0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      cnv_cmplt <= 1'b0;
      a2d_err   <= 1'b0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      wrt       <= start_wrt;
      cnv_cmplt <= capture;

      if (start_wrt) begin
        cmd     <= chan_cmd;
        tmo_cnt <= '0;
      end else if (state == CMD || state == READ) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (timeout) a2d_err <= 1'b1;

      if (capture) begin
        rr_ptr <= rr_ptr + 2'd1;
        case (rr_ptr)
          2'd0:    lft_ld    <= rd_data[11:0];
          2'd1:    rght_ld   <= rd_data[11:0];
          2'd2:    steer_pot <= rd_data[11:0];
          default: batt      <= rd_data[11:0];
        endcase
      end
    end
  end

endmodule

// File: doc/a2d_seq.md
Name: a2d_seq

Overview:
- Round-robin sequencer for the external 8-channel SPI A2D converter.
- Drives the existing SPI master through a wrt/done handshake, two transactions per conversion.
- Captures 12-bit results into per-signal holding registers: left load cell, right load cell, steering pot and battery.
- Its outputs feed steering enable, balance control and battery monitoring.
- A conversion is started by an external nxt pulse, typically the IMU/PID update tick.

Parameters:
- TMO_CYCLES, 4096: max clocks to wait for SPI done before aborting the conversion.

Ports:
- clk  input  1  50MHz system clock
- rst_n  input  1  asynchronous active-low reset
- nxt  input  1  single-cycle request to start the next conversion
- done  input  1  SPI master transaction complete, 1-cycle pulse
- rd_data  input  16  SPI master received word
- wrt  output  1  SPI master start-transaction pulse
- cmd  output  16  SPI word to transmit
- lft_ld  output  12  left load cell result (A2D ch0)
- rght_ld  output  12  right load cell result (A2D ch4)
- steer_pot  output  12  steering pot result (A2D ch5)
- batt  output  12  battery result (A2D ch6)
- cnv_cmplt  output  1  1-cycle pulse when a result register has updated
- a2d_err  output  1  sticky flag, set on SPI timeout

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0.
  - wrt=0, cmd=0, cnv_cmplt=0, a2d_err=0.
  - All four result registers=0.
- rr_ptr is 2 bits, sequence 0,1,2,3 and wrap to 0, mapping to ch0, ch4, ch5, ch6.
- cmd = {2'b00, ch[2:0], 11'h000}, giving 0x0000, 0x2000, 0x2800, 0x3000. cmd is registered and held stable from the wrt cycle until the next wrt.
- FSM states: IDLE, CMD, GAP, READ. wrt is a registered 1-cycle pulse.
- IDLE:
  - nxt=1 -> next cycle wrt=1 with the channel cmd; go to CMD.
  - done is ignored in IDLE.
- CMD:
  - Wait for done.
  - On done -> go to GAP; no data is captured from this transaction.
- GAP:
  - Exactly one clock.
  - Then wrt=1 with the same cmd; go to READ.
- READ:
  - Wait for done.
  - On the clock where done=1: the register selected by rr_ptr <= rd_data[11:0] (rd_data[15:12] discarded); rr_ptr increments; go to IDLE.
  - cnv_cmplt=1 on the following cycle only.
- Latency: nxt to cnv_cmplt = 2 + (CMD SPI time) + 1 + (READ SPI time) + 1 clocks.
- nxt in any state other than IDLE is ignored, not queued.
- nxt during the cnv_cmplt cycle is accepted, because the state is already IDLE.
- Timeout:
  - A 12-bit+ counter clears on every wrt and counts while in CMD or READ.
  - Reaching TMO_CYCLES without done -> a2d_err<=1, go to IDLE.
  - On timeout: rr_ptr unchanged (the same channel is retried on the next nxt), no register update, no cnv_cmplt.
- a2d_err clears only on reset.
- Only one result register changes per conversion; the other three hold their values.
- Reset mid-transaction: immediate return to IDLE with all reset values. done arriving later is ignored.

Test Plan:
- Reset check: assert rst_n=0 with nxt/done toggling -> all outputs 0, no wrt while reset is held.
- First conversion: nxt; model done 40 clocks after each wrt; rd_data=0xFABC on the second transaction. Required response:
  - wrt count=2, both with cmd=0x0000.
  - lft_ld=0xABC, other result registers 0.
  - cnv_cmplt exactly once, one cycle after the second done.
- Round robin: 5 nxt pulses with rd_data 0x111, 0x222, 0x333, 0x444, 0x555. Required response:
  - cmds 0x0000, 0x2000, 0x2800, 0x3000, 0x0000.
  - Final lft_ld=0x555, rght_ld=0x222, steer_pot=0x333, batt=0x444.
- Busy rejection: extra nxt pulses during CMD, GAP and READ -> exactly 2 wrt per accepted nxt and a single cnv_cmplt. Back-to-back nxt in the cnv_cmplt cycle starts the next channel.
- Timeout: with TMO_CYCLES=64, withhold done after the first wrt. Required response:
  - a2d_err rises 64 clocks after that wrt; state returns to IDLE; no cnv_cmplt.
  - Next nxt reissues the same cmd (0x0000); a2d_err stays 1.
- Reset mid-READ: pull rst_n low for 3 clocks between the second wrt and its done, then deliver done. Required response: registers 0, cnv_cmplt never pulses, next nxt uses cmd 0x0000.
